// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Holds the requester count, index width and the arbiter state encoding.
package rr_arb_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Expand a binary requester index into its one-hot grant vector.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_priority_encoder_8.sv
// Rotating-priority 8-to-3 encoder: returns the first unmasked request at or after Ptr.
// Purely combinational; the caller registers the result.
module rr_priority_encoder_8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] Req,
    input  logic [IDX_W-1:0] Ptr,
    input  logic [N_REQ-1:0] Mask,
    output logic [IDX_W-1:0] Idx,
    output logic             Found
);

    logic [N_REQ-1:0] candidates;

    assign candidates = Req & ~Mask;

    // Walk the candidates from Ptr upwards, wrapping at 7; the first hit wins.
    always_comb begin
        logic [IDX_W-1:0] pos;
        Idx   = '0;
        Found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = Ptr + IDX_W'(k);
            if (!Found && candidates[pos]) begin
                Found = 1'b1;
                Idx   = pos;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with bounded grant locking.
// Registered one-hot grant plus encoded index; priority rotates past each served owner.
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Enable,
    input  logic [N_REQ-1:0] Req,
    output logic [N_REQ-1:0] Gnt,
    output logic [IDX_W-1:0] Gnt_Idx,
    output logic             Valid
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  ptr_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nx;
    logic [N_REQ-1:0]  gnt_nx;
    logic [IDX_W-1:0]  idx_nx;
    logic              valid_nx;

    logic [IDX_W-1:0]  search_ptr;
    logic [N_REQ-1:0]  search_mask;
    logic [IDX_W-1:0]  winner;
    logic              winner_found;
    logic              owner_req;
    logic              others_req;
    logic [IDX_W-1:0]  next_after_owner;

    // While busy, the search starts just past the owner and skips it, so a
    // preempt or release always moves on to somebody else.
    assign next_after_owner = Gnt_Idx + IDX_W'(1);
    assign search_ptr       = (state == BUSY) ? next_after_owner : ptr;
    assign search_mask      = (state == BUSY) ? Gnt : '0;
    assign owner_req        = |(Req & Gnt);
    assign others_req       = |(Req & ~Gnt);

    rr_priority_encoder_8 u_encoder (
        .Req   (Req),
        .Ptr   (search_ptr),
        .Mask  (search_mask),
        .Idx   (winner),
        .Found (winner_found)
    );

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        hold_nx  = hold_cnt;
        gnt_nx   = Gnt;
        idx_nx   = Gnt_Idx;
        valid_nx = Valid;

        case (state)
            IDLE: begin
                if (Enable && winner_found) begin
                    state_nx = BUSY;
                    gnt_nx   = idx_to_onehot(winner);
                    idx_nx   = winner;
                    valid_nx = 1'b1;
                    hold_nx  = HOLD_W'(1);
                end else begin
                    gnt_nx   = '0;
                    idx_nx   = '0;
                    valid_nx = 1'b0;
                    hold_nx  = '0;
                end
            end

            BUSY: begin
                if (!Enable) begin
                    // Disabling counts as having served the current owner.
                    state_nx = IDLE;
                    ptr_nx   = next_after_owner;
                    gnt_nx   = '0;
                    idx_nx   = '0;
                    valid_nx = 1'b0;
                    hold_nx  = '0;
                end else if (!owner_req || (others_req && hold_cnt >= HOLD_LIMIT)) begin
                    ptr_nx = next_after_owner;
                    if (winner_found) begin
                        gnt_nx   = idx_to_onehot(winner);
                        idx_nx   = winner;
                        valid_nx = 1'b1;
                        hold_nx  = HOLD_W'(1);
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = '0;
                        idx_nx   = '0;
                        valid_nx = 1'b0;
                        hold_nx  = '0;
                    end
                end else if (hold_cnt < HOLD_LIMIT) begin
                    hold_nx = hold_cnt + HOLD_W'(1);
                end
            end

            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                idx_nx   = '0;
                valid_nx = 1'b0;
                hold_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            Gnt      <= '0;
            Gnt_Idx  <= '0;
            Valid    <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
            Gnt      <= gnt_nx;
            Gnt_Idx  <= idx_nx;
            Valid    <= valid_nx;
        end
    end

endmodule
